// File: rtl/rx_pkg.sv
// Shared types and defaults for the receive frame synchroniser.
package rx_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEARCH  = 2'd1,
        LENGTH  = 2'd2,
        PAYLOAD = 2'd3
    } state_t;

    localparam int unsigned SYNC_WIDTH_DEF = 16;
    localparam logic [15:0] SYNC_WORD_DEF  = 16'hD391;
    localparam int unsigned LEN_WIDTH_DEF  = 8;
    localparam int unsigned MAX_SEARCH_DEF = 256;
    localparam int unsigned CNT_WIDTH_DEF  = 9;
    localparam int unsigned BYTE_WIDTH     = 8;

endpackage

// File: rtl/rx_sync_correlator.sv
// Sync-word correlator: serial shift register compared against the sync word
// and its complement, evaluated on the register contents including the current bit.
module rx_sync_correlator
    import rx_pkg::*;
#(
    parameter int unsigned           SYNC_WIDTH = SYNC_WIDTH_DEF,
    parameter logic [SYNC_WIDTH-1:0] SYNC_WORD  = SYNC_WORD_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_shift,
    input  logic i_bit,
    output logic o_match_c,
    output logic o_match_inv_c
);

    // The oldest bit falls off on the next shift, so only SYNC_WIDTH-1 bits are stored.
    logic [SYNC_WIDTH-2:0] r_sr;
    logic [SYNC_WIDTH-1:0] w_sr_next;

    assign w_sr_next     = {r_sr, i_bit};
    assign o_match_c     = (w_sr_next == SYNC_WORD);
    assign o_match_inv_c = (w_sr_next == ~SYNC_WORD);

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_sr <= '0;
        end else if (i_shift) begin
            r_sr <= w_sr_next[SYNC_WIDTH-2:0];
        end
    end

endmodule

// File: rtl/rx_frame_sync.sv
// Frame synchroniser: sync search with phase-ambiguity resolution, length parse
// and MSB-first payload deframing, handing control back to the packet detector.
module rx_frame_sync
    import rx_pkg::*;
#(
    parameter int unsigned           SYNC_WIDTH = SYNC_WIDTH_DEF,
    parameter logic [SYNC_WIDTH-1:0] SYNC_WORD  = SYNC_WORD_DEF,
    parameter int unsigned           LEN_WIDTH  = LEN_WIDTH_DEF,
    parameter int unsigned           MAX_SEARCH = MAX_SEARCH_DEF,
    parameter int unsigned           CNT_WIDTH  = CNT_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clk_enable,
    input  logic                  BPSK,
    input  logic                  PD_flag,
    output logic                  disassert_PD,
    output logic                  FS_flag,
    output logic                  phase_inv,
    output logic [LEN_WIDTH-1:0]  frame_len,
    output logic [BYTE_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  frame_start,
    output logic                  frame_end,
    output logic                  frame_err
);

    localparam int unsigned BIT_CNT_W = (LEN_WIDTH > BYTE_WIDTH) ? $clog2(LEN_WIDTH)
                                                                 : $clog2(BYTE_WIDTH);

    state_t                  r_state, w_state_nxt;
    logic                    r_armed, w_armed_nxt;
    logic [CNT_WIDTH-1:0]    r_search_cnt, w_search_cnt_nxt;
    logic [BIT_CNT_W-1:0]    r_bit_cnt, w_bit_cnt_nxt;
    logic [LEN_WIDTH-1:0]    r_byte_cnt, w_byte_cnt_nxt;
    logic [BYTE_WIDTH-2:0]   r_byte_sr, w_byte_sr_nxt;
    logic [LEN_WIDTH-1:0]    r_frame_len, w_frame_len_nxt;
    logic                    r_phase_inv, w_phase_inv_nxt;
    logic                    r_fs_flag, w_fs_flag_nxt;
    logic [BYTE_WIDTH-1:0]   r_data_out, w_data_out_nxt;
    logic                    r_data_valid, w_data_valid_nxt;
    logic                    r_frame_start, w_frame_start_nxt;
    logic                    r_frame_end, w_frame_end_nxt;
    logic                    r_frame_err, w_frame_err_nxt;
    logic                    r_disassert, w_disassert_nxt;

    logic                    w_corr_clear;
    logic                    w_corr_shift;
    logic                    w_match;
    logic                    w_match_inv;
    logic                    w_sync_ok;
    logic                    w_abort;
    logic                    w_bit;
    logic [LEN_WIDTH-1:0]    w_len_shift;
    logic [BYTE_WIDTH-1:0]   w_byte;

    rx_sync_correlator #(
        .SYNC_WIDTH (SYNC_WIDTH),
        .SYNC_WORD  (SYNC_WORD)
    ) u_corr (
        .clk           (clk),
        .rst           (rst),
        .i_clear       (w_corr_clear),
        .i_shift       (w_corr_shift),
        .i_bit         (BPSK),
        .o_match_c     (w_match),
        .o_match_inv_c (w_match_inv)
    );

    // A match inside the first SYNC_WIDTH-1 symbols would be against the cleared register.
    assign w_sync_ok   = (w_match || w_match_inv) &&
                         (r_search_cnt >= CNT_WIDTH'(SYNC_WIDTH - 1));
    assign w_abort     = (r_state != IDLE) && !PD_flag;
    assign w_bit       = BPSK ^ r_phase_inv;
    assign w_len_shift = {r_frame_len[LEN_WIDTH-2:0], w_bit};
    assign w_byte      = {r_byte_sr, w_bit};

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt       = r_state;
        w_armed_nxt       = r_armed;
        w_search_cnt_nxt  = r_search_cnt;
        w_bit_cnt_nxt     = r_bit_cnt;
        w_byte_cnt_nxt    = r_byte_cnt;
        w_byte_sr_nxt     = r_byte_sr;
        w_frame_len_nxt   = r_frame_len;
        w_phase_inv_nxt   = r_phase_inv;
        w_fs_flag_nxt     = r_fs_flag;
        w_data_out_nxt    = r_data_out;
        w_data_valid_nxt  = 1'b0;
        w_frame_start_nxt = 1'b0;
        w_frame_end_nxt   = 1'b0;
        w_frame_err_nxt   = 1'b0;
        w_disassert_nxt   = 1'b0;
        w_corr_clear      = 1'b0;
        w_corr_shift      = 1'b0;

        if (w_abort) begin
            // Detector has already dropped the flag, so no disassert back to it.
            w_state_nxt     = IDLE;
            w_frame_err_nxt = 1'b1;
            w_fs_flag_nxt   = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_corr_clear     = 1'b1;
                    w_search_cnt_nxt = '0;
                    if (!PD_flag) begin
                        w_armed_nxt = 1'b1;
                    end else if (clk_enable && r_armed) begin
                        w_state_nxt = SEARCH;
                        w_armed_nxt = 1'b0;
                    end
                end
                SEARCH: begin
                    if (clk_enable) begin
                        w_corr_shift     = 1'b1;
                        w_search_cnt_nxt = r_search_cnt + CNT_WIDTH'(1);
                        if (w_sync_ok) begin
                            w_phase_inv_nxt   = !w_match;
                            w_frame_start_nxt = 1'b1;
                            w_fs_flag_nxt     = 1'b1;
                            w_bit_cnt_nxt     = '0;
                            w_state_nxt       = LENGTH;
                        end else if (r_search_cnt == CNT_WIDTH'(MAX_SEARCH - 1)) begin
                            w_frame_err_nxt = 1'b1;
                            w_disassert_nxt = 1'b1;
                            w_state_nxt     = IDLE;
                        end
                    end
                end
                LENGTH: begin
                    if (clk_enable) begin
                        w_frame_len_nxt = w_len_shift;
                        w_bit_cnt_nxt   = r_bit_cnt + BIT_CNT_W'(1);
                        if (r_bit_cnt == BIT_CNT_W'(LEN_WIDTH - 1)) begin
                            w_bit_cnt_nxt = '0;
                            if (w_len_shift == '0) begin
                                w_frame_end_nxt = 1'b1;
                                w_disassert_nxt = 1'b1;
                                w_fs_flag_nxt   = 1'b0;
                                w_state_nxt     = IDLE;
                            end else begin
                                w_byte_cnt_nxt = '0;
                                w_state_nxt    = PAYLOAD;
                            end
                        end
                    end
                end
                PAYLOAD: begin
                    if (clk_enable) begin
                        w_byte_sr_nxt = {r_byte_sr[BYTE_WIDTH-3:0], w_bit};
                        w_bit_cnt_nxt = r_bit_cnt + BIT_CNT_W'(1);
                        if (r_bit_cnt == BIT_CNT_W'(BYTE_WIDTH - 1)) begin
                            w_bit_cnt_nxt    = '0;
                            w_data_out_nxt   = w_byte;
                            w_data_valid_nxt = 1'b1;
                            // frame_len is non-zero here, so the decrement cannot wrap.
                            if (r_byte_cnt == r_frame_len - LEN_WIDTH'(1)) begin
                                w_frame_end_nxt = 1'b1;
                                w_disassert_nxt = 1'b1;
                                w_fs_flag_nxt   = 1'b0;
                                w_state_nxt     = IDLE;
                            end else begin
                                w_byte_cnt_nxt = r_byte_cnt + LEN_WIDTH'(1);
                            end
                        end
                    end
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_armed       <= 1'b0;
            r_search_cnt  <= '0;
            r_bit_cnt     <= '0;
            r_byte_cnt    <= '0;
            r_byte_sr     <= '0;
            r_frame_len   <= '0;
            r_phase_inv   <= 1'b0;
            r_fs_flag     <= 1'b0;
            r_data_out    <= '0;
            r_data_valid  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_end   <= 1'b0;
            r_frame_err   <= 1'b0;
            r_disassert   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_armed       <= w_armed_nxt;
            r_search_cnt  <= w_search_cnt_nxt;
            r_bit_cnt     <= w_bit_cnt_nxt;
            r_byte_cnt    <= w_byte_cnt_nxt;
            r_byte_sr     <= w_byte_sr_nxt;
            r_frame_len   <= w_frame_len_nxt;
            r_phase_inv   <= w_phase_inv_nxt;
            r_fs_flag     <= w_fs_flag_nxt;
            r_data_out    <= w_data_out_nxt;
            r_data_valid  <= w_data_valid_nxt;
            r_frame_start <= w_frame_start_nxt;
            r_frame_end   <= w_frame_end_nxt;
            r_frame_err   <= w_frame_err_nxt;
            r_disassert   <= w_disassert_nxt;
        end
    end

    assign disassert_PD = r_disassert;
    assign FS_flag      = r_fs_flag;
    assign phase_inv    = r_phase_inv;
    assign frame_len    = r_frame_len;
    assign data_out     = r_data_out;
    assign data_valid   = r_data_valid;
    assign frame_start  = r_frame_start;
    assign frame_end    = r_frame_end;
    assign frame_err    = r_frame_err;

endmodule

// File: doc/rx_frame_sync.md
Name: rx_frame_sync

Overview:
Downstream of the packet-detection stage. Once PD_flag rises, it searches the hard-decided BPSK bit stream for a 16-bit sync word, resolving the 180° phase ambiguity along the way. It then parses an 8-bit length field and emits payload bytes MSB-first. At end of packet it pulses disassert_PD back to the detector so the detector re-arms for the next packet.

Parameters:
SYNC_WIDTH, 16, sync word length in bits
SYNC_WORD, 16'hD391, sync pattern, first-received bit in MSB
LEN_WIDTH, 8, payload length field width (unit: bytes)
MAX_SEARCH, 256, enabled symbols allowed in SEARCH before timeout
CNT_WIDTH, 9, width of the search/bit counters (must hold MAX_SEARCH)

Ports:
clk  in  1  clock
rst  in  1  reset (synchronous, active-high)
clk_enable  in  1  symbol strobe; all state advances only when high
BPSK  in  1  hard-decided symbol bit
PD_flag  in  1  packet-detected flag from detector (level)
disassert_PD  out  1  one-clk pulse: packet finished or search timed out
FS_flag  out  1  high from sync match until frame end/abort
phase_inv  out  1  latched: sync matched inverted; payload bits XOR 1
frame_len  out  LEN_WIDTH  latched length field
data_out  out  8  payload byte
data_valid  out  1  one-clk pulse, data_out valid
frame_start  out  1  one-clk pulse on sync match
frame_end  out  1  one-clk pulse after last byte, or after length field when length==0
frame_err  out  1  one-clk pulse on timeout or PD_flag loss mid-frame

Behaviour:
- Reset: state=IDLE; all outputs 0; shift register and counters 0.
- Every pulse output is high for exactly one clk: the clk_enable cycle on which its event occurs. Pulse outputs are 0 on every other cycle.
- IDLE: when PD_flag=1, go to SEARCH. Clear the shift register and search counter.
- SEARCH, on each enabled cycle:
  - sr_next = {sr[SYNC_WIDTH-2:0], BPSK}; search_cnt+1.
  - If sr_next==SYNC_WORD: phase_inv<=0, frame_start=1, FS_flag<=1, go to LENGTH.
  - Else if sr_next==~SYNC_WORD: phase_inv<=1, otherwise the same as a normal match.
  - A match is only valid once SYNC_WIDTH bits have been shifted since SEARCH entry (guards against the cleared register).
  - Else if search_cnt reaches MAX_SEARCH-1: pulse frame_err and disassert_PD, go to IDLE.
- LENGTH:
  - Shift LEN_WIDTH bits, each as (BPSK^phase_inv), MSB first, into frame_len.
  - On the last bit: if the value is 0, pulse frame_end and disassert_PD together, clear FS_flag, go to IDLE. Otherwise go to PAYLOAD with byte_cnt=0.
- PAYLOAD:
  - Shift 8 corrected bits per byte.
  - On the 8th bit, data_out<=byte and data_valid=1.
  - On the final byte (byte_cnt==frame_len-1), data_valid, frame_end and disassert_PD pulse on the same cycle; FS_flag<=0; go to IDLE.
- Latency: data_valid appears on the enabled cycle that samples the byte's 8th bit (registered output, visible the following clk).
- Abort: PD_flag=0 in SEARCH/LENGTH/PAYLOAD (any cycle, regardless of clk_enable) → go to IDLE next clk, pulse frame_err, clear FS_flag. disassert_PD is not pulsed (the detector is already cleared).
- IDLE holds while PD_flag=1 on the cycle right after disassert_PD (the detector clears it one clk later). Re-entry to SEARCH requires PD_flag to be seen low first: an armed bit is set in IDLE only after PD_flag==0.
- phase_inv and frame_len hold their values until the next sync match; data_out holds its last byte.
- rst mid-frame overrides everything: outputs return to reset values next clk, no pulses.
- Widths: byte_cnt is LEN_WIDTH bits. The compare uses frame_len-1 only in PAYLOAD, where frame_len≥1, so there is no underflow.

Decomposition:
- Shared package rx_pkg:
  - state enum (IDLE, SEARCH, LENGTH, PAYLOAD)
  - SYNC_WORD default
  - LEN_WIDTH
  - BYTE_WIDTH=8
- One natural sub-module, rx_sync_correlator: shift register plus normal/inverted match, with outputs match and match_inv. The FSM, counters and deframer stay in rx_frame_sync.

Test Plan:
- PD_flag=1, stream 0101… then D391, len=02, bytes A5,3C → frame_start at sync bit 16, phase_inv=0, data_valid twice with A5 then 3C, frame_end + disassert_PD on the 3C cycle.
- Same packet, all bits inverted → phase_inv=1, frame_len=02, data_out A5,3C.
- Sync + len=00 → frame_end and disassert_PD on the 8th length bit, no data_valid.
- PD_flag=1 with no sync for 256 enabled symbols → frame_err + disassert_PD at symbol 256, FS_flag stays 0.
- PD_flag dropped after first payload byte → frame_err next clk, no disassert_PD, no further data_valid.
- clk_enable high 1-in-4, plus rst asserted mid-PAYLOAD → byte timing scales with enables; after rst all outputs 0 and the next packet decodes correctly.
